// File: rtl/beam_threshold_loader.sv
// rtl/beam_threshold_loader.sv - shadow threshold array streamed atomically into the beamformer
// Optional feature macro: BEAM_THRESH_MASK_EN (adds beam_mask_i, masked beams stream all-ones)
module beam_threshold_loader #(
   parameter int NUM_BEAM    = 48,
   parameter int THRESH_BITS = 18,
   parameter int ADDR_BITS   = 6
) (
   input  logic                   aclk,
   input  logic                   arst,
   input  logic                   wr_valid_i,
   output logic                   wr_ready_o,
   input  logic [ADDR_BITS-1:0]   wr_addr_i,
   input  logic [THRESH_BITS-1:0] wr_data_i,
   input  logic                   commit_i,
`ifdef BEAM_THRESH_MASK_EN
   input  logic [NUM_BEAM-1:0]    beam_mask_i,
`endif
   output logic                   busy_o,
   output logic                   err_o,
   input  logic                   err_clr_i,
   output logic                   thresh_wr_o,
   output logic [ADDR_BITS-1:0]   thresh_addr_o,
   output logic [THRESH_BITS-1:0] thresh_data_o,
   output logic                   thresh_update_o
);

   localparam logic [ADDR_BITS-1:0] LAST_BEAM = ADDR_BITS'(NUM_BEAM - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ADDR_BITS-1:0]   cnt;
   logic [ADDR_BITS-1:0]   cnt_nxt;
   logic                   pending;
   logic                   pending_nxt;
   logic [THRESH_BITS-1:0] shadow [NUM_BEAM];
   logic [THRESH_BITS-1:0] rd_val;
   logic                   wr_fire;
   logic                   wr_bad;

`ifdef BEAM_THRESH_MASK_EN
   logic [NUM_BEAM-1:0]    mask_q;
   logic [NUM_BEAM-1:0]    mask_use;
`endif

   assign wr_fire = wr_valid_i & wr_ready_o;
   assign wr_bad  = wr_fire & (wr_addr_i > LAST_BEAM);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      case (state)
         IDLE: begin
            if (commit_i || pending) begin
               state_nxt   = LOAD;
               cnt_nxt     = '0;
               pending_nxt = 1'b0;
            end
         end
         LOAD: begin
            if (commit_i) pending_nxt = 1'b1;
            if (cnt == LAST_BEAM) state_nxt = UPDATE;
            else cnt_nxt = cnt + 1'b1;
         end
         UPDATE: begin
            if (commit_i) pending_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef BEAM_THRESH_MASK_EN
   // The first beam is emitted on the commit edge itself, so use the live mask then.
   assign mask_use = (state == IDLE) ? beam_mask_i : mask_q;
`endif

   // Beam 0 is read on the commit edge; a same-cycle write must bypass the array.
   always_comb begin
      rd_val = shadow[cnt_nxt];
      if (wr_fire && !wr_bad && (wr_addr_i == cnt_nxt)) rd_val = wr_data_i;
`ifdef BEAM_THRESH_MASK_EN
      if (mask_use[cnt_nxt]) rd_val = '1;
`endif
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state           <= IDLE;
         cnt             <= '0;
         pending         <= 1'b0;
         wr_ready_o      <= 1'b0;
         busy_o          <= 1'b0;
         err_o           <= 1'b0;
         thresh_wr_o     <= 1'b0;
         thresh_addr_o   <= '0;
         thresh_data_o   <= '0;
         thresh_update_o <= 1'b0;
         for (int i = 0; i < NUM_BEAM; i++) shadow[i] <= '1;
`ifdef BEAM_THRESH_MASK_EN
         mask_q          <= '0;
`endif
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         pending         <= pending_nxt;
         wr_ready_o      <= (state_nxt == IDLE);
         busy_o          <= (state_nxt != IDLE) | pending_nxt;
         thresh_wr_o     <= (state_nxt == LOAD);
         thresh_update_o <= (state_nxt == UPDATE);
         if (state_nxt == LOAD) begin
            thresh_addr_o <= cnt_nxt;
            thresh_data_o <= rd_val;
         end
         if (wr_fire && !wr_bad) shadow[wr_addr_i] <= wr_data_i;
         if (wr_bad) err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;
`ifdef BEAM_THRESH_MASK_EN
         if (state == IDLE) mask_q <= beam_mask_i;
`endif
      end
   end

endmodule
